// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access controller.
// Turns the EX/MEM memory-control bundle into a byte-lane-aligned request on
// a variable-latency RAM port, stalls the pipeline until the port
// acknowledges, and returns aligned, extended load data. Misaligned accesses
// and bus timeouts are flagged.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mem_read_flag/mem_write_flag load / store request
//   mem_ext_flag/mem_signed_flag narrow-load extension controls
//   mem_sel                      unshifted size mask (0001/0011/1111)
//   mem_write_data, mem_addr     store datum (low bits) and byte address
//   flush                        pipeline flush
//   ram_en, ram_write_en         RAM request and byte write enables
//   ram_addr, ram_write_data     word address and lane-replicated store data
//   ram_read_data, ram_ack       RAM read data and one-cycle completion strobe
//   stall_request                freeze upstream stages (combinational)
//   load_data, load_valid        aligned/extended load result and its pulse
//   addr_error                   misaligned access (combinational)
//   bus_error                    timeout pulse
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_flag,
    input  logic        mem_write_flag,
    input  logic        mem_ext_flag,
    input  logic        mem_signed_flag,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_write_data,
    input  logic [31:0] mem_addr,
    input  logic        flush,
    output logic        ram_en,
    output logic [3:0]  ram_write_en,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data,
    input  logic        ram_ack,
    output logic        stall_request,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        addr_error,
    output logic        bus_error
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Last WAIT count value before the timeout fires.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ram_en_q, ram_en_d;
    logic [3:0]  ram_we_q, ram_we_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic        rd_q, rd_d;
    logic        ext_q, ext_d;
    logic        sgn_q, sgn_d;
    logic [3:0]  sel_q, sel_d;
    logic [1:0]  off_q, off_d;
    logic        flush_seen_q, flush_seen_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        bus_error_q, bus_error_d;

    logic        access_c;
    logic        mis_c;
    logic        issue_c;
    logic        stall_c;
    logic [3:0]  lanes_c;
    logic [31:0] wdata_rep_c;
    logic [31:0] rshift_c;
    logic [31:0] extract_c;

    // Request decode: access, misalignment, byte lanes, replicated store data.
    always_comb begin
        access_c = mem_read_flag | mem_write_flag;
        mis_c    = ((mem_sel == 4'b1111) && (mem_addr[1:0] != 2'b00)) |
                   ((mem_sel == 4'b0011) && mem_addr[0]);
        lanes_c  = 4'(mem_sel << mem_addr[1:0]);
        case (mem_sel)
            4'b0001: wdata_rep_c = {4{mem_write_data[7:0]}};
            4'b0011: wdata_rep_c = {2{mem_write_data[15:0]}};
            default: wdata_rep_c = mem_write_data;
        endcase
    end

    // Issue is blocked during the bus_error cycle: the request still on the
    // inputs is the one that just timed out and the pipeline moves past it.
    assign issue_c = access_c & ~mis_c & ~flush & ~bus_error_q;

    // Load extraction from the captured offset and size/extension controls.
    always_comb begin
        rshift_c  = ram_read_data >> {off_q, 3'b000};
        extract_c = rshift_c;
        if (ext_q) begin
            if (sel_q == 4'b0001) begin
                extract_c = sgn_q ? {{24{rshift_c[7]}}, rshift_c[7:0]}
                                  : {24'd0, rshift_c[7:0]};
            end else if (sel_q == 4'b0011) begin
                extract_c = sgn_q ? {{16{rshift_c[15]}}, rshift_c[15:0]}
                                  : {16'd0, rshift_c[15:0]};
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ram_en_d     = ram_en_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        rd_d         = rd_q;
        ext_d        = ext_q;
        sgn_d        = sgn_q;
        sel_d        = sel_q;
        off_d        = off_q;
        flush_seen_d = flush_seen_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        bus_error_d  = 1'b0;
        stall_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (issue_c) begin
                    stall_c      = 1'b1;
                    ram_en_d     = 1'b1;
                    ram_we_d     = mem_write_flag ? lanes_c : 4'b0000;
                    ram_addr_d   = {mem_addr[31:2], 2'b00};
                    ram_wdata_d  = wdata_rep_c;
                    rd_d         = mem_read_flag & ~mem_write_flag;
                    ext_d        = mem_ext_flag;
                    sgn_d        = mem_signed_flag;
                    sel_d        = mem_sel;
                    off_d        = mem_addr[1:0];
                    flush_seen_d = 1'b0;
                    cnt_d        = 8'd0;
                    state_d      = ST_WAIT;
                end
            end

            ST_WAIT: begin
                stall_c      = 1'b1;
                cnt_d        = cnt_q + 8'd1;
                flush_seen_d = flush_seen_q | flush;
                // Ack takes priority over a coincident timeout.
                if (ram_ack) begin
                    ram_en_d = 1'b0;
                    ram_we_d = 4'b0000;
                    if (rd_q) begin
                        load_data_d  = extract_c;
                        load_valid_d = ~(flush_seen_q | flush);
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    ram_en_d    = 1'b0;
                    ram_we_d    = 4'b0000;
                    bus_error_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 4'b0000;
            ram_addr_q   <= 32'd0;
            ram_wdata_q  <= 32'd0;
            rd_q         <= 1'b0;
            ext_q        <= 1'b0;
            sgn_q        <= 1'b0;
            sel_q        <= 4'b0000;
            off_q        <= 2'b00;
            flush_seen_q <= 1'b0;
            load_data_q  <= 32'd0;
            load_valid_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            rd_q         <= rd_d;
            ext_q        <= ext_d;
            sgn_q        <= sgn_d;
            sel_q        <= sel_d;
            off_q        <= off_d;
            flush_seen_q <= flush_seen_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            bus_error_q  <= bus_error_d;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign stall_request  = stall_c & ~rst;
    assign addr_error     = (state_q == ST_IDLE) & access_c & mis_c & ~rst;

    assign ram_en         = ram_en_q;
    assign ram_write_en   = ram_we_q;
    assign ram_addr       = ram_addr_q;
    assign ram_write_data = ram_wdata_q;
    assign load_data      = load_data_q;
    assign load_valid     = load_valid_q;
    assign bus_error      = bus_error_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage data-memory access controller, directly downstream of the ID-stage memory-control generator.
- Consumes the memory-control bundle (read/write/ext flags, size mask, store data) carried through EX/MEM, plus the EX-computed address.
- Converts the bundle into byte-lane-aligned requests on a variable-latency RAM port, stalls the pipeline until the port acknowledges, and returns aligned, extended load data.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255, maximum WAIT cycles before aborting (range 1..255; counter is 8 bits).

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read_flag  in  1  load request.
- mem_write_flag  in  1  store request.
- mem_ext_flag  in  1  narrow load; result must be extended.
- mem_signed_flag  in  1  with mem_ext_flag: 1 = sign-extend, 0 = zero-extend.
- mem_sel  in  4  size mask, unshifted: 0001 byte, 0011 half, 1111 word.
- mem_write_data  in  32  store data; the datum is in the low bits.
- mem_addr  in  32  byte address.
- flush  in  1  pipeline flush.
- ram_en  out  1  RAM request.
- ram_write_en  out  4  byte write enables; 0000 for loads.
- ram_addr  out  32  word address, equal to {mem_addr[31:2], 2'b00}.
- ram_write_data  out  32  lane-replicated store data.
- ram_read_data  in  32  RAM read data; valid while ram_ack is high.
- ram_ack  in  1  one-cycle completion strobe.
- stall_request  out  1  freeze upstream stages.
- load_data  out  32  aligned and extended load result.
- load_valid  out  1  load_data valid, one-cycle pulse.
- addr_error  out  1  misaligned access, combinational.
- bus_error  out  1  timeout, one-cycle pulse.

Behaviour:
- Reset:
  - State IDLE, timeout counter 0.
  - All outputs 0, including ram_write_en = 0000, load_data = 0.
  - Reset in any state aborts immediately. An outstanding ram_ack arriving later is ignored.
- Access detection: access = mem_read_flag | mem_write_flag.
- Misalignment:
  - mis = (mem_sel == 1111 && mem_addr[1:0] != 0) | (mem_sel == 0011 && mem_addr[0]).
  - In IDLE, addr_error = access & mis. The access is not issued and stall_request stays 0.
- Byte lanes (little endian):
  - Enable = mem_sel << mem_addr[1:0].
  - Store data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- Load extraction:
  - r = ram_read_data >> (8 * mem_addr[1:0]).
  - mem_ext_flag = 0: result is r.
  - Byte: sign- or zero-extend r[7:0] per mem_signed_flag. Half: the same using r[15:0].
- FSM states: IDLE, WAIT, DONE.
  - IDLE:
    - On access & !mis & !flush: stall_request = 1 combinationally in this cycle.
    - Register ram_en = 1, ram_write_en, ram_addr, ram_write_data, the read flag, the extract controls and the low address bits. Clear the counter. Next state WAIT.
    - Otherwise remain in IDLE.
  - WAIT:
    - stall_request = 1. RAM outputs are held stable.
    - The counter increments each cycle.
    - When ram_ack = 1:
      - For loads, register the extracted result into load_data.
      - ram_en drops to 0 and ram_write_en to 0000 on the next edge.
      - Next state DONE.
    - When counter reaches TIMEOUT with no ack:
      - Deassert ram_en and pulse bus_error.
      - load_valid is not asserted.
      - Next state IDLE.
      - stall_request drops in the cycle bus_error is high.
    - If ram_ack and timeout coincide, ack wins.
  - DONE:
    - stall_request = 0. load_valid = 1 for this cycle only, and only if the access was a load and no flush was seen.
    - Next state IDLE.
    - The pipeline advances at the end of DONE. The still-present request is not reissued.
- load_data:
  - Holds its value until the next load completes.
  - Store completion leaves load_data unchanged.
- flush:
  - In IDLE, flush suppresses issue.
  - In WAIT, flush is recorded: the transaction still completes on the bus, but load_valid is suppressed in DONE.
  - Flush has no effect in DONE.
- Back-to-back accesses:
  - Minimum three cycles each: IDLE, WAIT, DONE.
  - Zero-latency ack is not supported: ack is sampled only in WAIT, and ack in IDLE or DONE is ignored.

Test Plan:
- SB, addr 0x1003, data 0x12345678, ack after 1 WAIT cycle:
  - ram_write_en = 1000, ram_write_data = 0x78787878, ram_addr = 0x1000.
  - stall_request high 2 cycles.
  - No load_valid.
- LB vs LBU, addr 0x2002, ram_read_data 0x00F00000:
  - Signed: load_data = 0xFFFFFFF0.
  - Unsigned: load_data = 0x000000F0.
  - load_valid pulses once in DONE in each case.
- LW, addr 0x3000, ack after 3 WAIT cycles, data 0xDEADBEEF:
  - stall_request high 4 consecutive cycles.
  - load_data = 0xDEADBEEF.
  - ram_en low in DONE.
- Misaligned LW at 0x1002 and misaligned LH at 0x1001:
  - addr_error = 1.
  - ram_en and stall_request stay 0.
- Timeout, TIMEOUT = 4, no ack:
  - bus_error pulses once after 4 WAIT cycles.
  - ram_en drops and FSM returns to IDLE.
  - A subsequent access issues normally.
- rst asserted mid-WAIT, followed by a stray ram_ack:
  - All outputs return to 0 next cycle.
  - The ack is ignored and load_valid stays 0.
- flush during WAIT of an LH:
  - Transaction completes on the bus.
  - load_valid stays 0 and load_data is updated only internally.
